bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/rr_picker.sv | 36 +++
 rtl/bus_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the bus arbiter
// Contents:
//   t_arb_state  arbiter FSM state encoding (IDLE, ACCESS, DONE)
//   ARB_ADDR_W   slave word address width (byte address bits [31:2])
//   ARB_DATA_W   data bus width
//   ARB_STRB_W   byte strobe width
//   ARB_CNT_W    wait counter width, wide enough for the largest timeout
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } t_arb_state;

    localparam int ARB_ADDR_W = 30;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_STRB_W = 4;
    localparam int ARB_CNT_W  = 16;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection
// Ports:
//   request     in   per-master request vector
//   last_owner  in   index of the previously granted master
//   valid       out  at least one request is pending
//   winner      out  first requester searching upward from last_owner+1
module rr_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int OWNER_W     = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [OWNER_W-1:0]     last_owner,
    output logic                   valid,
    output logic [OWNER_W-1:0]     winner
);

    int idx;

    // Scan from the farthest offset down to the nearest one so the
    // requester closest after last_owner overwrites any earlier match.
    // Offset NUM_MASTERS lands on last_owner itself, giving it the lowest
    // priority of all pending requesters.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = (int'(last_owner) + i) % NUM_MASTERS;
            if (request[idx]) begin
                valid  = 1'b1;
                winner = OWNER_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin N-master to single-slave bus arbiter
// Ports:
//   clock, reset (async, active low)
//   m_request/m_address/m_data_out/m_data_strobes/m_write  master requests (packed per master)
//   m_ack/m_data_in/m_bus_error                             completion back to the owner (DONE only)
//   s_address/s_data_out/s_data_strobes/s_read/s_write      slave cycle (ACCESS only)
//   s_data_in/s_ready/s_bus_error                           slave completion
//   busy, owner                                             status
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int NUM_MASTERS    = 2,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int OWNER_W        = $clog2(NUM_MASTERS)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_request,
    input  logic [NUM_MASTERS*ARB_ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*ARB_DATA_W-1:0] m_data_out,
    input  logic [NUM_MASTERS*ARB_STRB_W-1:0] m_data_strobes,
    input  logic [NUM_MASTERS-1:0]            m_write,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [ARB_DATA_W-1:0]             m_data_in,
    output logic                              m_bus_error,
    output logic [ARB_ADDR_W-1:0]             s_address,
    output logic [ARB_DATA_W-1:0]             s_data_out,
    output logic [ARB_STRB_W-1:0]             s_data_strobes,
    output logic                              s_read,
    output logic                              s_write,
    input  logic [ARB_DATA_W-1:0]             s_data_in,
    input  logic                              s_ready,
    input  logic                              s_bus_error,
    output logic                              busy,
    output logic [OWNER_W-1:0]                owner
);

    // The counter starts at 0 in the first ACCESS cycle, so hitting
    // TIMEOUT_CYCLES-1 means this is the last permitted ACCESS cycle.
    localparam logic [ARB_CNT_W-1:0] TIMEOUT_LAST = ARB_CNT_W'(TIMEOUT_CYCLES - 1);

    t_arb_state                state;
    t_arb_state                state_next;
    logic [OWNER_W-1:0]        last_owner;
    logic [ARB_ADDR_W-1:0]     lat_addr;
    logic [ARB_DATA_W-1:0]     lat_wdata;
    logic [ARB_STRB_W-1:0]     lat_strb;
    logic                      lat_write;
    logic [ARB_DATA_W-1:0]     lat_rdata;
    logic                      lat_err;
    logic [ARB_CNT_W-1:0]      wait_cnt;
    logic                      pick_valid;
    logic [OWNER_W-1:0]        pick_winner;
    logic                      timeout_hit;
    logic                      slave_done;

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .OWNER_W     (OWNER_W)
    ) u_rr_picker (
        .request    (m_request),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
    assign slave_done  = s_ready | s_bus_error;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        m_ack          = '0;
        m_data_in      = '0;
        m_bus_error    = 1'b0;
        s_address      = '0;
        s_data_out     = '0;
        s_data_strobes = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        busy           = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                busy           = 1'b1;
                s_address      = lat_addr;
                s_data_out     = lat_wdata;
                s_data_strobes = lat_strb;
                s_read         = ~lat_write;
                s_write        = lat_write;
                if (slave_done || timeout_hit) begin
                    state_next = ARB_DONE;
                end
            end
            ARB_DONE: begin
                busy          = 1'b1;
                m_ack[owner]  = 1'b1;
                m_data_in     = lat_rdata;
                m_bus_error   = lat_err;
                state_next    = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner      <= '0;
            last_owner <= OWNER_W'(NUM_MASTERS - 1);
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_strb   <= '0;
            lat_write  <= 1'b0;
            lat_rdata  <= '0;
            lat_err    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_winner;
                        lat_addr  <= m_address[int'(pick_winner)*ARB_ADDR_W +: ARB_ADDR_W];
                        lat_wdata <= m_data_out[int'(pick_winner)*ARB_DATA_W +: ARB_DATA_W];
                        lat_strb  <= m_data_strobes[int'(pick_winner)*ARB_STRB_W +: ARB_STRB_W];
                        lat_write <= m_write[pick_winner];
                        wait_cnt  <= '0;
                    end
                end
                ARB_ACCESS: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (slave_done || timeout_hit) begin
                        // A slave completion (even coinciding with the timeout)
                        // wins over the timeout; bus_error wins over ready.
                        lat_rdata <= slave_done ? s_data_in : '0;
                        lat_err   <= s_bus_error | ~s_ready;
                    end
                end
                ARB_DONE: begin
                    last_owner <= owner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
